// File: rtl/rc4_prga_decrypt_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rc4_pkg
// Description : Shared types and constants for the RC4 PRGA decrypt stage and
//               the plaintext character checker.
//               - state_t         : PRGA sequencer states
//               - S_DEPTH / S_AW  : S-box depth and index width
//               - CHAR_*          : accepted plaintext byte range
//               - is_valid_char() : byte -> plaintext-valid
// Revision    : 1.0  initial release
// ============================================================================
package rc4_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    INC_I    = 4'd1,
    RD_SI    = 4'd2,
    WAIT_SI  = 4'd3,
    LATCH_SI = 4'd4,
    RD_SJ    = 4'd5,
    WAIT_SJ  = 4'd6,
    LATCH_SJ = 4'd7,
    WR_SI    = 4'd8,
    WR_SJ    = 4'd9,
    RD_F     = 4'd10,
    WAIT_F   = 4'd11,
    LATCH_F  = 4'd12,
    WR_DEC   = 4'd13,
    NEXT     = 4'd14,
    DONE     = 4'd15
  } state_t;

  localparam int S_DEPTH = 256;
  localparam int S_AW    = $clog2(S_DEPTH);

  localparam logic [7:0] CHAR_LO    = 8'h61;
  localparam logic [7:0] CHAR_HI    = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // Lower-case letters and space are the only bytes a correct key produces.
  function automatic logic is_valid_char(input logic [7:0] b);
    return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SPACE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rc4_prga_decrypt_fsm_char_check.sv
`default_nettype none
// ============================================================================
// Module      : rc4_char_check
// Description : Combinational plaintext-byte classifier, also used by the
//               key-search controller.
// Ports       : data  in  8  byte to classify
//               valid out 1  1 = 'a'..'z' or space
// Revision    : 1.0  initial release
// ============================================================================
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] data,
  output logic       valid
);

  assign valid = is_valid_char(data);

endmodule
`default_nettype wire

// File: rtl/rc4_prga_decrypt_fsm.sv
`default_nettype none
// ============================================================================
// Module      : rc4_prga_decrypt_fsm
// Description : RC4 pseudo-random generation stage. Walks the shuffled S array
//               held in the shared S-RAM, XORs each keystream byte with the
//               encrypted ROM and writes the result to the decrypted RAM.
//               Every output byte is classified so a wrong key is rejected
//               early (ABORT_ON_INVALID=1) or reported at the end.
// Ports       : clk, reset (async, active-low)
//               start        in   begin a run (sampled in IDLE only)
//               stop         in   abort request, taken at byte boundary
//               s_q          in   S-RAM read data
//               s_address/s_data/s_wren   out  S-RAM port
//               enc_q        in   encrypted ROM read data
//               enc_address  out  encrypted ROM address
//               dec_address/dec_data/dec_wren  out  decrypted RAM port
//               busy/done/pass  out  run status
// Revision    : 1.0  initial release
// ============================================================================
module rc4_prga_decrypt_fsm
  import rc4_pkg::*;
#(
  parameter  int MSG_LEN          = 32,
  parameter  int ABORT_ON_INVALID = 1,
  localparam int AW               = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [7:0]    s_q,
  output logic [7:0]    s_address,
  output logic [7:0]    s_data,
  output logic          s_wren,
  input  logic [7:0]    enc_q,
  output logic [AW-1:0] enc_address,
  output logic [AW-1:0] dec_address,
  output logic [7:0]    dec_data,
  output logic          dec_wren,
  output logic          busy,
  output logic          done,
  output logic          pass
);

  localparam logic [AW-1:0] K_LAST = AW'(MSG_LEN - 1);

  typedef logic [S_AW-1:0] sidx_t;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t        r_state;
  sidx_t         r_i;
  sidx_t         r_j;
  logic [AW-1:0] r_k;
  logic [7:0]    r_si;
  logic [7:0]    r_sj;
  logic          r_fail;

  // Next-state values; every output is registered from its *_nxt so that the
  // value tied to a state is present for that state's whole cycle.
  state_t        w_state_nxt;
  sidx_t         w_i_nxt;
  sidx_t         w_j_nxt;
  logic [AW-1:0] w_k_nxt;
  logic [7:0]    w_si_nxt;
  logic [7:0]    w_sj_nxt;
  logic          w_fail_nxt;
  logic [7:0]    w_s_address_nxt;
  logic [7:0]    w_s_data_nxt;
  logic          w_s_wren_nxt;
  logic [AW-1:0] w_enc_address_nxt;
  logic [AW-1:0] w_dec_address_nxt;
  logic [7:0]    w_dec_data_nxt;
  logic          w_dec_wren_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic          w_pass_nxt;

  logic          w_dec_valid;
  logic          w_last;
  logic          w_abort_inv;

  // The byte being written in WR_DEC is already on dec_data, so the checker
  // looks at the registered output rather than re-deriving f^e.
  rc4_char_check u_char_check (
    .data  (dec_data),
    .valid (w_dec_valid)
  );

  assign w_last      = (r_k == K_LAST);
  assign w_abort_inv = (ABORT_ON_INVALID != 0) && r_fail;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_si        <= '0;
      r_sj        <= '0;
      r_fail      <= 1'b0;
      s_address   <= '0;
      s_data      <= '0;
      s_wren      <= 1'b0;
      enc_address <= '0;
      dec_address <= '0;
      dec_data    <= '0;
      dec_wren    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_i         <= w_i_nxt;
      r_j         <= w_j_nxt;
      r_k         <= w_k_nxt;
      r_si        <= w_si_nxt;
      r_sj        <= w_sj_nxt;
      r_fail      <= w_fail_nxt;
      s_address   <= w_s_address_nxt;
      s_data      <= w_s_data_nxt;
      s_wren      <= w_s_wren_nxt;
      enc_address <= w_enc_address_nxt;
      dec_address <= w_dec_address_nxt;
      dec_data    <= w_dec_data_nxt;
      dec_wren    <= w_dec_wren_nxt;
      busy        <= w_busy_nxt;
      done        <= w_done_nxt;
      pass        <= w_pass_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_i_nxt           = r_i;
    w_j_nxt           = r_j;
    w_k_nxt           = r_k;
    w_si_nxt          = r_si;
    w_sj_nxt          = r_sj;
    w_fail_nxt        = r_fail;
    w_s_address_nxt   = s_address;
    w_s_data_nxt      = s_data;
    w_s_wren_nxt      = 1'b0;
    w_enc_address_nxt = enc_address;
    w_dec_address_nxt = dec_address;
    w_dec_data_nxt    = dec_data;
    w_dec_wren_nxt    = 1'b0;
    w_busy_nxt        = busy;
    w_done_nxt        = done;
    w_pass_nxt        = pass;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = INC_I;
          w_i_nxt     = '0;
          w_j_nxt     = '0;
          w_k_nxt     = '0;
          w_fail_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_pass_nxt  = 1'b0;
        end
      end

      INC_I: begin
        w_i_nxt         = r_i + 8'd1;
        w_s_address_nxt = r_i + 8'd1;
        w_state_nxt     = RD_SI;
      end

      RD_SI:   w_state_nxt = WAIT_SI;
      WAIT_SI: w_state_nxt = LATCH_SI;

      LATCH_SI: begin
        w_si_nxt        = s_q;
        w_j_nxt         = r_j + s_q;
        w_s_address_nxt = r_j + s_q;
        w_state_nxt     = RD_SJ;
      end

      RD_SJ:   w_state_nxt = WAIT_SJ;
      WAIT_SJ: w_state_nxt = LATCH_SJ;

      LATCH_SJ: begin
        w_sj_nxt        = s_q;
        w_s_address_nxt = r_i;
        w_s_data_nxt    = s_q;
        w_s_wren_nxt    = 1'b1;
        w_state_nxt     = WR_SI;
      end

      // When i==j both writes carry the same byte to the same address, which
      // leaves S unchanged exactly as a swap with itself should.
      WR_SI: begin
        w_s_address_nxt = r_j;
        w_s_data_nxt    = r_si;
        w_s_wren_nxt    = 1'b1;
        w_state_nxt     = WR_SJ;
      end

      WR_SJ: begin
        w_s_address_nxt   = r_si + r_sj;
        w_enc_address_nxt = r_k;
        w_state_nxt       = RD_F;
      end

      RD_F:   w_state_nxt = WAIT_F;
      WAIT_F: w_state_nxt = LATCH_F;

      // f and e are consumed only as their XOR, so the plaintext byte is the
      // only thing kept from this read.
      LATCH_F: begin
        w_dec_address_nxt = r_k;
        w_dec_data_nxt    = s_q ^ enc_q;
        w_dec_wren_nxt    = 1'b1;
        w_state_nxt       = WR_DEC;
      end

      WR_DEC: begin
        if (!w_dec_valid) begin
          w_fail_nxt = 1'b1;
        end
        w_state_nxt = NEXT;
      end

      NEXT: begin
        w_k_nxt = r_k + AW'(1);
        if (stop || w_last || w_abort_inv) begin
          w_state_nxt = DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = w_last && !r_fail && !stop;
        end else begin
          w_state_nxt = INC_I;
        end
      end

      DONE: begin
        if (!start) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b0;
          w_pass_nxt  = 1'b0;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rc4_prga_decrypt_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_rc4_prga_decrypt_fsm
// Description : Bench for rc4_prga_decrypt_fsm. Two instances: unit 0 with
//               MSG_LEN=9/no abort, unit 1 with MSG_LEN=14/abort on invalid.
//               Each has its own S-RAM / ROM / decrypted-RAM model with one
//               cycle of read latency. Expected results come from a plain
//               RC4 PRGA model working on arrays.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rc4_prga_decrypt_fsm;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      start = '0;
  logic [1:0]      stop  = '0;
  logic [1:0][7:0] s_q;
  logic [1:0][7:0] s_addr;
  logic [1:0][7:0] s_data;
  logic [1:0]      s_wren;
  logic [1:0][7:0] enc_q;
  logic [1:0][3:0] enc_addr;
  logic [1:0][3:0] dec_addr;
  logic [1:0][7:0] dec_data;
  logic [1:0]      dec_wren;
  logic [1:0]      busy;
  logic [1:0]      done;
  logic [1:0]      pass;

  rc4_prga_decrypt_fsm #(.MSG_LEN(9), .ABORT_ON_INVALID(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .stop(stop[0]),
    .s_q(s_q[0]), .s_address(s_addr[0]), .s_data(s_data[0]), .s_wren(s_wren[0]),
    .enc_q(enc_q[0]), .enc_address(enc_addr[0]),
    .dec_address(dec_addr[0]), .dec_data(dec_data[0]), .dec_wren(dec_wren[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0])
  );

  rc4_prga_decrypt_fsm #(.MSG_LEN(14), .ABORT_ON_INVALID(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .stop(stop[1]),
    .s_q(s_q[1]), .s_address(s_addr[1]), .s_data(s_data[1]), .s_wren(s_wren[1]),
    .enc_q(enc_q[1]), .enc_address(enc_addr[1]),
    .dec_address(dec_addr[1]), .dec_data(dec_data[1]), .dec_wren(dec_wren[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1])
  );

  // Memory models plus activity counters; loading goes through ld_* so each
  // array has a single writing process.
  logic [7:0] smem [2][256];
  logic [7:0] rom  [2][256];
  logic [7:0] decm [2][256];
  int         wr_cnt   [2] = '{0, 0};
  int         swr_cnt  [2] = '{0, 0};
  int         busy_cnt [2] = '{0, 0};
  logic [1:0] ld_en = '0;
  logic [7:0] ld_addr = '0;
  logic [7:0] ld_sdat = '0;
  logic [7:0] ld_rdat = '0;

  for (genvar g = 0; g < 2; g++) begin : g_mem
    always @(posedge clk) begin
      s_q[g]   <= smem[g][s_addr[g]];
      enc_q[g] <= rom[g][enc_addr[g]];
      if (ld_en[g]) begin
        smem[g][ld_addr] <= ld_sdat;
        rom[g][ld_addr]  <= ld_rdat;
        decm[g][ld_addr] <= 8'h00;
      end else begin
        if (s_wren[g]) begin
          smem[g][s_addr[g]] <= s_data[g];
          swr_cnt[g] <= swr_cnt[g] + 1;
        end
        if (dec_wren[g]) begin
          decm[g][dec_addr[g]] <= dec_data[g];
          wr_cnt[g] <= wr_cnt[g] + 1;
        end
      end
      if (busy[g]) busy_cnt[g] <= busy_cnt[g] + 1;
    end
  end

  // --------------------------------------------------------------------------
  // Bookkeeping and reference model
  // --------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ld_s   [256];
  logic [7:0] ld_rom [256];
  logic [7:0] m_s    [256];
  logic [7:0] m_rom  [256];
  logic [7:0] m_dec  [256];
  logic [7:0] ks     [256];
  int         m_nwr, m_i, m_j;
  bit         m_pass;
  int         run_wr, run_busy;

  logic [7:0] pt  [9]  = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] ct  [9]  = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] atk [14] = '{"a","t","t","a","c","k"," ","a","t"," ","d","a","w","n"};
  logic [7:0] key [3]  = '{8'h4B, 8'h65, 8'h79};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit tb_valid(input logic [7:0] b);
    return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
  endfunction

  function automatic logic [63:0] outs(input int g);
    return 64'({s_addr[g], s_data[g], s_wren[g], enc_addr[g], dec_addr[g],
                dec_data[g], dec_wren[g], busy[g], done[g], pass[g]});
  endfunction

  // Textbook RC4 PRGA on m_s / m_rom. stop_byte >= 0 ends after that byte.
  task automatic model_run(input int msg_len, input bit abort_inv, input int stop_byte);
    int i, j;
    logic [7:0] t, o;
    bit fl;
    i = 0; j = 0; fl = 0; m_nwr = 0; m_pass = 0;
    for (int k = 0; k < msg_len; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(m_s[i])) % 256;
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      o = m_s[(int'(m_s[i]) + int'(m_s[j])) % 256] ^ m_rom[k];
      m_dec[k] = o;
      m_nwr++;
      if (!tb_valid(o)) fl = 1;
      m_i = i; m_j = j;
      if (k == stop_byte) return;
      if (abort_inv && fl) return;
    end
    m_pass = !fl;
  endtask

  task automatic prep_model();
    for (int n = 0; n < 256; n++) begin
      m_s[n] = ld_s[n];
      m_rom[n] = ld_rom[n];
    end
  endtask

  task automatic ksa_key();
    int j;
    logic [7:0] t;
    j = 0;
    for (int n = 0; n < 256; n++) ld_s[n] = 8'(n);
    for (int n = 0; n < 256; n++) begin
      j = (j + int'(ld_s[n]) + int'(key[n % 3])) % 256;
      t = ld_s[n]; ld_s[n] = ld_s[j]; ld_s[j] = t;
    end
  endtask

  task automatic rand_perm();
    int r;
    logic [7:0] t;
    for (int n = 0; n < 256; n++) ld_s[n] = 8'(n);
    for (int n = 255; n > 0; n--) begin
      r = int'($urandom_range(n, 0));
      t = ld_s[n]; ld_s[n] = ld_s[r]; ld_s[r] = t;
    end
  endtask

  // Keystream of the current ld_s into ks[].
  task automatic gen_ks();
    for (int n = 0; n < 256; n++) begin
      m_s[n] = ld_s[n];
      m_rom[n] = 8'h00;
    end
    model_run(14, 0, -1);
    for (int n = 0; n < 14; n++) ks[n] = m_dec[n];
  endtask

  task automatic load(input int g);
    for (int n = 0; n < 256; n++) begin
      @(negedge clk);
      ld_en[g] = 1'b1;
      ld_addr  = 8'(n);
      ld_sdat  = ld_s[n];
      ld_rdat  = ld_rom[n];
    end
    @(negedge clk);
    ld_en = '0;
  endtask

  task automatic do_run(input int g, input int stop_wr);
    int wr0, bz0;
    bit ok;
    ok = 0; wr0 = wr_cnt[g]; bz0 = busy_cnt[g];
    start[g] = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (stop_wr > 0 && (wr_cnt[g] - wr0) >= stop_wr) stop[g] = 1'b1;
      if (done[g]) begin
        ok = 1;
        break;
      end
    end
    stop[g] = 1'b0;
    chk($sformatf("u%0d_done_reached", g), 64'(ok), 64'd1);
    run_wr = wr_cnt[g] - wr0;
    run_busy = busy_cnt[g] - bz0;
  endtask

  task automatic check_run(input int g, input string tag);
    chk({tag, "_nwr"}, 64'(run_wr), 64'(m_nwr));
    chk({tag, "_busy_cycles"}, 64'(run_busy), 64'(14 * m_nwr));
    chk({tag, "_done"}, 64'(done[g]), 64'd1);
    chk({tag, "_busy"}, 64'(busy[g]), 64'd0);
    chk({tag, "_pass"}, 64'(pass[g]), 64'(m_pass));
    for (int k = 0; k < m_nwr; k++)
      chk($sformatf("%s_dec[%0d]", tag, k), 64'(decm[g][k]), 64'(m_dec[k]));
  endtask

  task automatic finish_run(input int g);
    start[g] = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic cmp_sram(input int g, input string tag);
    int bad;
    bad = 0;
    for (int n = 0; n < 256; n++) if (smem[g][n] !== m_s[n]) bad++;
    chk(tag, 64'(bad), 64'd0);
  endtask

  // --------------------------------------------------------------------------
  // Directed and random sequence
  // --------------------------------------------------------------------------
  initial begin
    int base, p;
    bit hit;

    // Reset state
    repeat (2) @(negedge clk);
    chk("u0_reset_outputs", outs(0), 64'd0);
    chk("u1_reset_outputs", outs(1), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // "Plaintext" vector, no abort: all 9 bytes, 'P' makes pass=0
    ksa_key();
    for (int n = 0; n < 256; n++) ld_rom[n] = (n < 9) ? ct[n] : 8'h00;
    load(0);
    load(1);
    prep_model();
    model_run(9, 0, -1);
    do_run(0, 0);
    check_run(0, "plain");
    for (int n = 0; n < 9; n++) chk($sformatf("plain_const[%0d]", n), 64'(decm[0][n]), 64'(pt[n]));
    chk("plain_busy_126", 64'(run_busy), 64'd126);
    finish_run(0);

    // Same vector, abort on invalid: single write of 0x50 at address 0
    prep_model();
    model_run(14, 1, -1);
    do_run(1, 0);
    check_run(1, "abort");
    chk("abort_one_write", 64'(run_wr), 64'd1);
    chk("abort_byte0", 64'(decm[1][0]), 64'h50);
    finish_run(1);

    // "attack at dawn": pass=1 and final S matches the model
    ksa_key();
    gen_ks();
    for (int n = 0; n < 256; n++) ld_rom[n] = (n < 14) ? (ks[n] ^ atk[n]) : 8'h00;
    load(1);
    prep_model();
    model_run(14, 1, -1);
    do_run(1, 0);
    check_run(1, "attack");
    chk("attack_pass", 64'(pass[1]), 64'd1);
    for (int n = 0; n < 14; n++) chk($sformatf("attack_const[%0d]", n), 64'(decm[1][n]), 64'(atk[n]));
    cmp_sram(1, "attack_final_sram");
    finish_run(1);

    // stop during byte 3, then start held keeps DONE, drop start -> IDLE
    load(1);
    prep_model();
    model_run(14, 1, 3);
    do_run(1, 4);
    check_run(1, "stop");
    repeat (5) @(negedge clk);
    chk("stop_hold_done", 64'(done[1]), 64'd1);
    chk("stop_hold_busy", 64'(busy[1]), 64'd0);
    start[1] = 1'b0;
    @(negedge clk);
    chk("stop_idle_done", 64'(done[1]), 64'd0);
    chk("stop_idle_pass", 64'(pass[1]), 64'd0);
    @(negedge clk);

    // Reset pulse in WR_SJ of byte 2 (sixth S-RAM write cycle)
    load(1);
    base = swr_cnt[1];
    hit = 0;
    start[1] = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (s_wren[1] && (swr_cnt[1] - base) == 5) begin
        hit = 1;
        break;
      end
    end
    chk("rst_reached_wr_sj", 64'(hit), 64'd1);
    reset = 1'b0;
    #1;
    chk("rst_outputs_zero", outs(1), 64'd0);
    start[1] = 1'b0;
    @(negedge clk);
    chk("rst_outputs_held", outs(1), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    // S-RAM: two full swaps plus only the S[i] half of the third
    prep_model();
    model_run(2, 0, -1);
    p = (m_j + int'(m_s[3])) % 256;
    m_s[3] = m_s[p];
    cmp_sram(1, "rst_partial_sram");
    model_run(14, 1, -1);
    do_run(1, 0);
    check_run(1, "rst_restart");
    finish_run(1);

    // Identity S, zero ROM: first byte is s[2]=2 after a self-swap at i=j=1
    for (int n = 0; n < 256; n++) begin
      ld_s[n] = 8'(n);
      ld_rom[n] = 8'h00;
    end
    load(1);
    prep_model();
    model_run(14, 1, -1);
    do_run(1, 0);
    check_run(1, "ident");
    chk("ident_byte0", 64'(decm[1][0]), 64'd2);
    finish_run(1);

    // Random S permutations and ciphertexts
    for (int t = 0; t < 3; t++) begin
      rand_perm();
      for (int n = 0; n < 256; n++) ld_rom[n] = 8'($urandom);
      load(0);
      prep_model();
      model_run(9, 0, -1);
      do_run(0, 0);
      check_run(0, $sformatf("rnd0_%0d", t));
      cmp_sram(0, $sformatf("rnd0_%0d_sram", t));
      finish_run(0);
    end
    for (int t = 0; t < 3; t++) begin
      rand_perm();
      gen_ks();
      p = int'($urandom_range(16, 0));
      for (int n = 0; n < 256; n++) begin
        ld_rom[n] = 8'h00;
        if (n < 14) begin
          if (n == p) ld_rom[n] = ks[n] ^ 8'($urandom_range(31, 0));
          else if ($urandom_range(4, 0) == 0) ld_rom[n] = ks[n] ^ 8'h20;
          else ld_rom[n] = ks[n] ^ 8'($urandom_range(8'h7A, 8'h61));
        end
      end
      load(1);
      prep_model();
      model_run(14, 1, -1);
      do_run(1, 0);
      check_run(1, $sformatf("rnd1_%0d", t));
      cmp_sram(1, $sformatf("rnd1_%0d_sram", t));
      finish_run(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
